// File: rtl/sat_pkg.sv
// Shared types for the SAT implication path.
//   impl_t : one implication, {variable index, implied value}
//   IMPL_W : packed width of impl_t
// MAX_VARS_BITS normally comes from the system definitions. A default is
// supplied here so the package builds on its own.
`ifndef MAX_VARS_BITS
`define MAX_VARS_BITS 8
`endif

package sat_pkg;
  localparam int VAR_BITS = `MAX_VARS_BITS;

  typedef struct packed {
    logic [VAR_BITS-1:0] var_idx;
    logic                val;
  } impl_t;

  localparam int IMPL_W = $bits(impl_t);
endpackage

// File: rtl/impl_cam_match.sv
// Combinational match of a probe implication against all queue entries.
// Ports:
//   entries_i  : queue storage, one impl_t per slot
//   valid_i    : per-slot occupancy mask
//   probe_i    : incoming implication
//   hit_same_o : some valid slot holds the same variable with the same value
//   hit_opp_o  : some valid slot holds the same variable with the opposite value
module impl_cam_match
  import sat_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  impl_t [DEPTH-1:0] entries_i,
  input  logic  [DEPTH-1:0] valid_i,
  input  impl_t             probe_i,
  output logic              hit_same_o,
  output logic              hit_opp_o
);
  always_comb begin
    hit_same_o = 1'b0;
    hit_opp_o  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_i[i] && entries_i[i].var_idx == probe_i.var_idx) begin
        if (entries_i[i].val == probe_i.val) hit_same_o = 1'b1;
        else                                 hit_opp_o  = 1'b1;
      end
    end
  end
endmodule

// File: rtl/implication_queue.sv
// Implication queue between the unit clause evaluators and the BCP stage.
// Buffers unit implications, hands one per cycle downstream over valid/ready,
// and raises a sticky conflict when an incoming implication contradicts a
// queued one. Flushed by the backtrack controller.
// Ports:
//   clock, reset (sync, active-high), flush (drop all, clear conflict)
//   in_valid/in_unit/in_var/in_val/in_ready : evaluator result handshake
//   out_valid/out_var/out_val/out_ready     : head entry handshake
//   count    : entries held
//   conflict : sticky contradictory-implication flag
// Configuration: define IMPL_QUEUE_DEDUP_EN to drop exact duplicates of a
// queued implication instead of storing them again.
// VAR_BITS must equal sat_pkg::VAR_BITS (storage uses sat_pkg::impl_t).
module implication_queue
  import sat_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int VAR_BITS = sat_pkg::VAR_BITS
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic                     in_unit,
  input  logic [VAR_BITS-1:0]      in_var,
  input  logic                     in_val,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [VAR_BITS-1:0]      out_var,
  output logic                     out_val,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     conflict
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  impl_t [DEPTH-1:0] mem_q;
  logic  [PW-1:0]    rd_q, wr_q, rd_d;
  logic  [CW-1:0]    cnt_q, cnt_d;
  logic              conf_q;
  impl_t             head_q, head_d;

  impl_t             probe;
  logic [DEPTH-1:0]  vmask;
  logic              hit_same, hit_opp, dup_drop;
  logic              accept, store, pop, conf_set;

  assign probe = '{var_idx: in_var, val: in_val};

  // Slot i is occupied when its distance from the read pointer (mod DEPTH)
  // is below the count; this covers the full case where wr == rd.
  always_comb begin
    vmask = '0;
    for (int i = 0; i < DEPTH; i++)
      vmask[i] = CW'(PW'(PW'(i) - rd_q)) < cnt_q;
  end

  impl_cam_match #(.DEPTH(DEPTH)) u_cam (
    .entries_i  (mem_q),
    .valid_i    (vmask),
    .probe_i    (probe),
    .hit_same_o (hit_same),
    .hit_opp_o  (hit_opp)
  );

`ifdef IMPL_QUEUE_DEDUP_EN
  assign dup_drop = hit_same;
`else
  logic dedup_unused;
  assign dedup_unused = hit_same;
  assign dup_drop     = 1'b0;
`endif

  // Readiness depends only on registered state (and reset), never on out_ready.
  assign in_ready  = !reset && (cnt_q != CW'(DEPTH)) && !conf_q;
  assign out_valid = (cnt_q != '0) && !conf_q;
  assign accept    = in_valid && in_ready;
  assign conf_set  = accept && in_unit && hit_opp;
  assign store     = accept && in_unit && !hit_opp && !dup_drop;
  assign pop       = out_valid && out_ready;

  // Head register: next cycle's head is the newly written entry when the
  // queue drains to it this cycle, otherwise whatever sits at the next rd.
  always_comb begin
    rd_d   = rd_q + PW'(pop);
    cnt_d  = cnt_q + CW'(store) - CW'(pop);
    head_d = head_q;
    if (cnt_d != '0)
      head_d = (store && wr_q == rd_d) ? probe : mem_q[rd_d];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
      conf_q <= 1'b0;
      head_q <= '0;
    end else if (flush) begin
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
      conf_q <= 1'b0;
    end else begin
      rd_q   <= rd_d;
      wr_q   <= wr_q + PW'(store);
      cnt_q  <= cnt_d;
      head_q <= head_d;
      if (conf_set) conf_q <= 1'b1;
    end
  end

  // Storage needs no reset: occupancy is tracked by rd/count only.
  always_ff @(posedge clock) begin
    if (!reset && !flush && store) mem_q[wr_q] <= probe;
  end

  assign out_var  = head_q.var_idx;
  assign out_val  = head_q.val;
  assign count    = cnt_q;
  assign conflict = conf_q;
endmodule

// File: tb/tb_implication_queue.sv
module tb_implication_queue;
  localparam int DEPTH = 16;
  localparam int VB    = 8;
`ifdef IMPL_QUEUE_DEDUP_EN
  localparam bit DEDUP = 1'b1;
`else
  localparam bit DEDUP = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          rst = 1'b1, flush = 1'b0;
  logic          iv = 1'b0, iu = 1'b0, ival = 1'b0, ordy = 1'b0;
  logic [VB-1:0] ivar = '0;
  logic          in_ready, out_valid, out_val, conflict;
  logic [VB-1:0] out_var;
  logic [4:0]    count;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  implication_queue #(.DEPTH(DEPTH), .VAR_BITS(VB)) dut (
    .clock(clock), .reset(rst), .flush(flush),
    .in_valid(iv), .in_unit(iu), .in_var(ivar), .in_val(ival),
    .in_ready(in_ready), .out_valid(out_valid), .out_var(out_var),
    .out_val(out_val), .out_ready(ordy), .count(count), .conflict(conflict)
  );

  // Reference model: a plain FIFO of implications plus a conflict flag.
  typedef struct { logic [VB-1:0] v; logic b; } ent_t;
  ent_t mq[$];
  bit   mconf;
  ent_t mh;

  task automatic model_update();
    bit acc, pp, opp, same;
    acc = 0; pp = 0; opp = 0; same = 0;
    if (rst) begin
      mq.delete(); mconf = 0; mh.v = '0; mh.b = 1'b0;
    end else if (flush) begin
      mq.delete(); mconf = 0;
    end else begin
      acc = iv && (mq.size() < DEPTH) && !mconf;
      pp  = (mq.size() > 0) && !mconf && ordy;
      if (acc && iu)
        foreach (mq[k]) if (mq[k].v == ivar) begin
          if (mq[k].b == ival) same = 1; else opp = 1;
        end
      if (pp) void'(mq.pop_front());
      if (acc && iu) begin
        if (opp) mconf = 1;
        else if (!(DEDUP && same)) mq.push_back('{ivar, ival});
      end
      if (mq.size() > 0) mh = mq[0];
    end
  endtask

  task automatic step();
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic set_in(input logic v, input logic u, input int var_i,
                        input logic b, input logic r);
    iv = v; iu = u; ivar = VB'(var_i); ival = b; ordy = r;
  endtask

  task automatic test_reset();
    rst = 1; flush = 0; set_in(0, 0, 0, 0, 0);
    step();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_ready_hi got=%0b exp=0", in_ready); end
    step();
    total++; if (count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    total++; if (conflict !== 1'b0) begin bad++; $display("FAIL reset_conflict got=%0b exp=0", conflict); end
    total++; if (out_var !== 8'd0 || out_val !== 1'b0) begin bad++; $display("FAIL reset_out got=%0d/%0b exp=0/0", out_var, out_val); end
    rst = 0; #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready_after got=%0b exp=1", in_ready); end
  endtask

  task automatic test_push_pop();
    set_in(1, 1, 5, 1, 0); step();
    set_in(1, 1, 9, 0, 0); step();
    set_in(0, 0, 0, 0, 0); step();
    total++; if (count !== 5'd2) begin bad++; $display("FAIL pp_count got=%0d exp=2", count); end
    total++; if (out_valid !== 1'b1 || out_var !== 8'd5 || out_val !== 1'b1)
      begin bad++; $display("FAIL pp_head got=%0b/%0d/%0b exp=1/5/1", out_valid, out_var, out_val); end
    ordy = 1; step(); ordy = 0;
    total++; if (out_var !== 8'd9 || out_val !== 1'b0 || count !== 5'd1)
      begin bad++; $display("FAIL pp_pop got=%0d/%0b cnt=%0d exp=9/0 cnt=1", out_var, out_val, count); end
    ordy = 1; step(); ordy = 0;
    total++; if (count !== 5'd0 || out_valid !== 1'b0) begin bad++; $display("FAIL pp_drain cnt=%0d ov=%0b exp=0/0", count, out_valid); end
  endtask

  task automatic test_full_wrap();
    int n;
    for (int i = 0; i < DEPTH; i++) begin set_in(1, 1, i, 1'($urandom), 0); step(); end
    set_in(0, 0, 0, 0, 0); #1;
    total++; if (count !== 5'd16 || in_ready !== 1'b0) begin bad++; $display("FAIL full cnt=%0d rdy=%0b exp=16/0", count, in_ready); end
    // pop while full: still not ready that cycle
    ordy = 1; iv = 1; iu = 1; ivar = 8'd40; #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_pop_ready got=%0b exp=0", in_ready); end
    step();
    total++; if (count !== 5'd15) begin bad++; $display("FAIL full_pop_cnt got=%0d exp=15", count); end
    set_in(1, 1, 16, 0, 1); step();
    total++; if (count !== 5'd15) begin bad++; $display("FAIL push_pop_cnt got=%0d exp=15", count); end
    set_in(0, 0, 0, 0, 1);
    n = 0;
    while (mq.size() > 0 && n < 40) begin
      total++; if (out_var !== mh.v || out_val !== mh.b)
        begin bad++; $display("FAIL drain_head got=%0d/%0b exp=%0d/%0b", out_var, out_val, mh.v, mh.b); end
      step(); n++;
    end
    total++; if (count !== 5'd0 || n >= 40) begin bad++; $display("FAIL drain_end cnt=%0d cycles=%0d", count, n); end
    set_in(1, 1, 20, 1, 0); step(); set_in(0, 0, 0, 0, 0);
    total++; if (out_valid !== 1'b1 || out_var !== 8'd20 || out_val !== 1'b1 || count !== 5'd1)
      begin bad++; $display("FAIL wrap_push got=%0b/%0d/%0b cnt=%0d exp=1/20/1 cnt=1", out_valid, out_var, out_val, count); end
    ordy = 1; step(); ordy = 0;
  endtask

  task automatic test_conflict();
    set_in(1, 1, 7, 1, 0); step();
    set_in(1, 1, 7, 0, 0); step();
    set_in(0, 0, 0, 0, 0);
    total++; if (conflict !== 1'b1 || out_valid !== 1'b0 || count !== 5'd1 || in_ready !== 1'b0)
      begin bad++; $display("FAIL conflict_set c=%0b ov=%0b cnt=%0d rdy=%0b exp=1/0/1/0", conflict, out_valid, count, in_ready); end
    set_in(1, 1, 33, 1, 1); step(); set_in(0, 0, 0, 0, 0);
    total++; if (count !== 5'd1 || conflict !== 1'b1) begin bad++; $display("FAIL conflict_hold cnt=%0d c=%0b exp=1/1", count, conflict); end
    flush = 1; step(); flush = 0;
    total++; if (conflict !== 1'b0 || count !== 5'd0) begin bad++; $display("FAIL conflict_flush c=%0b cnt=%0d exp=0/0", conflict, count); end
    set_in(1, 1, 7, 1, 0); step();
    set_in(1, 1, 7, 0, 1); step(); set_in(0, 0, 0, 0, 0);
    total++; if (conflict !== 1'b1 || count !== 5'd0) begin bad++; $display("FAIL conflict_popped c=%0b cnt=%0d exp=1/0", conflict, count); end
    flush = 1; step(); flush = 0;
  endtask

  task automatic test_dedup();
    set_in(1, 1, 3, 1, 0); step(); step(); set_in(0, 0, 0, 0, 0);
    total++; if (count !== (DEDUP ? 5'd1 : 5'd2)) begin bad++; $display("FAIL dedup_cnt got=%0d exp=%0d", count, DEDUP ? 1 : 2); end
    total++; if (conflict !== 1'b0) begin bad++; $display("FAIL dedup_conflict got=%0b exp=0", conflict); end
    flush = 1; step(); flush = 0;
  endtask

  task automatic test_nonunit_flush();
    set_in(1, 0, 4, 1, 0); step();
    total++; if (count !== 5'd0) begin bad++; $display("FAIL nonunit_cnt got=%0d exp=0", count); end
    set_in(1, 1, 1, 1, 0); step();
    flush = 1; set_in(1, 1, 2, 0, 1); step(); flush = 0; set_in(0, 0, 0, 0, 0);
    total++; if (count !== 5'd0 || out_valid !== 1'b0) begin bad++; $display("FAIL flush_push cnt=%0d ov=%0b exp=0/0", count, out_valid); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      rst   = ($urandom_range(0, 299) == 0);
      flush = ($urandom_range(0, 24) == 0);
      set_in(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) != 0),
             $urandom_range(0, 47), 1'($urandom), 1'($urandom_range(0, 2) == 0));
      step();
      total++; if (count !== 5'(mq.size())) begin bad++; $display("FAIL rnd_count c=%0d got=%0d exp=%0d", c, count, mq.size()); end
      total++; if (conflict !== mconf) begin bad++; $display("FAIL rnd_conflict c=%0d got=%0b exp=%0b", c, conflict, mconf); end
      total++; if (out_valid !== (mq.size() > 0 && !mconf)) begin bad++; $display("FAIL rnd_out_valid c=%0d got=%0b", c, out_valid); end
      total++; if (in_ready !== (!rst && mq.size() < DEPTH && !mconf)) begin bad++; $display("FAIL rnd_in_ready c=%0d got=%0b", c, in_ready); end
      total++; if (out_var !== mh.v || out_val !== mh.b)
        begin bad++; $display("FAIL rnd_head c=%0d got=%0d/%0b exp=%0d/%0b", c, out_var, out_val, mh.v, mh.b); end
    end
    rst = 0; flush = 0; set_in(0, 0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_push_pop();
    test_full_wrap();
    test_conflict();
    test_dedup();
    test_nonunit_flush();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
